fft_bin_reader: RTL and testbench

- Consumes the streaming squared-magnitude output of the FFT top level: one bin per clock-enabled cycle, with a sync strobe on bin 0.
- Captures one frame of bins into an internal RAM, then drains it bin by bin over a valid/ready stream to a downstream reader (UART/display formatter).
- Frames that arrive while a drain is in progress are dropped and counted.

---
 rtl/fft_bin_reader.sv | 164 ++++++++++++++++
 tb/tb_fft_bin_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_bin_reader.sv
// fft_bin_reader: captures one frame of streaming FFT squared magnitudes into a
// local RAM, then drains it bin by bin over a valid/ready stream. Frames that
// arrive while a drain is in progress are dropped and counted (saturating).
// Optional build macro PEAK_TRACK_EN adds a running-max tracker (excluding DC)
// with outputs peak_mag / peak_index.
module fft_bin_reader #(
  parameter int WIDTH     = 12,
  parameter int LGN       = 6,
  parameter bit HALF_ONLY = 1'b1,
  localparam int MAG_W    = 2*WIDTH+2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bin_valid,
  input  logic             bin_sync,
  input  logic [MAG_W-1:0] bin_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_mag,
  output logic [LGN-1:0]   out_index,
  output logic             out_last,
  output logic             busy,
  output logic             sync_err,
  output logic [7:0]       drop_count
`ifdef PEAK_TRACK_EN
  ,
  output logic [MAG_W-1:0] peak_mag,
  output logic [LGN-1:0]   peak_index
`endif
);

  localparam int N    = 1 << LGN;
  localparam int NCAP = HALF_ONLY ? N/2 : N;
  localparam int CW   = (NCAP > 1) ? $clog2(NCAP) : 1;
  localparam int PW   = LGN + 1;
  localparam logic [CW-1:0] LAST_A = CW'(NCAP-1);
  localparam logic [PW-1:0] LAST_P = PW'(NCAP-1);
  localparam logic [PW-1:0] END_P  = PW'(NCAP);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [MAG_W-1:0] mem [NCAP];
  logic [CW-1:0]    wr_ptr, wr_addr;
  logic [PW-1:0]    rd_ptr;
  logic             cap_wr, cap_done, xfer, fetch;

  // Write/transfer qualifiers; a sync always lands at address 0 and restarts capture.
  // The output register is refilled whenever it is empty or being consumed, so
  // transfers run back to back with no bubbles.
  always_comb begin
    cap_wr   = bin_valid && ((state == CAPTURE) || ((state == IDLE) && bin_sync));
    wr_addr  = bin_sync ? '0 : wr_ptr;
    cap_done = cap_wr && (wr_addr == LAST_A);
    xfer     = out_valid && out_ready;
    fetch    = (state == DRAIN) && !(xfer && out_last) &&
               (!out_valid || xfer) && (rd_ptr != END_P);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_done) state_nxt = DRAIN;
               else if (cap_wr) state_nxt = CAPTURE;
      CAPTURE: if (cap_done) state_nxt = DRAIN;
      DRAIN:   if (xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame RAM write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (cap_wr) mem[wr_addr] <= bin_mag;
  end

  // Capture pointer and sticky resync flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      sync_err <= 1'b0;
    end else if (cap_wr) begin
      wr_ptr <= wr_addr + 1'b1;
      if ((state == CAPTURE) && bin_sync && (wr_ptr != '0)) sync_err <= 1'b1;
    end
  end

  // Drain: registered RAM read straight into the output holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (state != DRAIN) begin
      rd_ptr <= '0;
    end else if (fetch) begin
      out_mag   <= mem[rd_ptr[CW-1:0]];
      out_index <= rd_ptr[LGN-1:0];
      out_last  <= (rd_ptr == LAST_P);
      out_valid <= 1'b1;
      rd_ptr    <= rd_ptr + 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of frames that start while draining.
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else if ((state == DRAIN) && bin_valid && bin_sync && (drop_count != 8'hFF))
      drop_count <= drop_count + 8'd1;
  end

  assign busy = (state != IDLE);

`ifdef PEAK_TRACK_EN
  logic [MAG_W-1:0] run_mag, cand_mag;
  logic [LGN-1:0]   run_idx, cand_idx;

  // Running max including the bin being written now; bin 0 restarts it at 0/0,
  // strict compare keeps the lowest index on ties.
  always_comb begin
    cand_mag = run_mag;
    cand_idx = run_idx;
    if (wr_addr == '0) begin
      cand_mag = '0;
      cand_idx = '0;
    end else if (bin_mag > run_mag) begin
      cand_mag = bin_mag;
      cand_idx = LGN'(wr_addr);
    end
  end

  // Track during capture; publish when the frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_mag    <= '0;
      run_idx    <= '0;
      peak_mag   <= '0;
      peak_index <= '0;
    end else begin
      if (cap_wr) begin
        run_mag <= cand_mag;
        run_idx <= cand_idx;
      end
      if (cap_done) begin
        peak_mag   <= cand_mag;
        peak_index <= cand_idx;
      end
    end
  end
`else
  // Peak tracker not built.
`endif

endmodule

// File: tb/tb_fft_bin_reader.sv
// Directed bench for fft_bin_reader: full-frame instance (LGN=3, HALF_ONLY=0)
// and half-frame instance (LGN=3, HALF_ONLY=1) sharing the input stream.
module tb_fft_bin_reader;
  localparam int MW = 26;

  logic          clk = 1'b0;
  logic          reset, bin_valid, bin_sync, out_ready;
  logic [MW-1:0] bin_mag;
  logic          out_valid, out_last, busy, sync_err;
  logic [MW-1:0] out_mag;
  logic [2:0]    out_index;
  logic [7:0]    drop_count;
  logic          h_valid, h_last, h_busy, h_serr;
  logic [MW-1:0] h_mag;
  logic [2:0]    h_index;
  logic [7:0]    h_drop;
`ifdef PEAK_TRACK_EN
  logic [MW-1:0] f_pmag, h_pmag;
  logic [2:0]    f_pidx, h_pidx;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_bin_reader #(.WIDTH(12), .LGN(3), .HALF_ONLY(1'b0)) u_full (
    .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_sync(bin_sync),
    .bin_mag(bin_mag), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_index(out_index), .out_last(out_last),
    .busy(busy), .sync_err(sync_err), .drop_count(drop_count)
`ifdef PEAK_TRACK_EN
    , .peak_mag(f_pmag), .peak_index(f_pidx)
`endif
  );

  fft_bin_reader #(.WIDTH(12), .LGN(3), .HALF_ONLY(1'b1)) u_half (
    .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_sync(bin_sync),
    .bin_mag(bin_mag), .out_valid(h_valid), .out_ready(out_ready),
    .out_mag(h_mag), .out_index(h_index), .out_last(h_last),
    .busy(h_busy), .sync_err(h_serr), .drop_count(h_drop)
`ifdef PEAK_TRACK_EN
    , .peak_mag(h_pmag), .peak_index(h_pidx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input int stp, input int n);
    for (int i = 0; i < n; i++) begin
      bin_valid = 1'b1;
      bin_sync  = (i == 0);
      bin_mag   = MW'(base + stp*i);
      tick();
    end
    bin_valid = 1'b0;
    bin_sync  = 1'b0;
  endtask

  // Drains the full instance and checks order/content; bp toggles ready 1,0,0,1;
  // sync_last drives a frame sync on the cycle of the final transfer.
  task automatic drain(input int base, input int stp, input int n, input bit bp, input bit sync_last);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      bin_valid = 1'b0;
      bin_sync  = 1'b0;
      if (out_valid) begin
        chk("drain_index", out_index, k);
        chk("drain_mag", out_mag, base + stp*k);
        chk("drain_last", out_last, (k == n-1));
        if (sync_last && out_last && out_ready) begin
          bin_valid = 1'b1;
          bin_sync  = 1'b1;
        end
        if (out_ready) k++;
      end
      tick();
      cyc++;
    end
    bin_valid = 1'b0;
    bin_sync  = 1'b0;
    chk("drain_count", k, n);
    chk("drain_end_valid", out_valid, 0);
    chk("drain_end_busy", busy, 0);
  endtask

  initial begin
    int hm[4];
    hm = '{500, 7, 9, 9};
    reset = 1'b1; bin_valid = 1'b0; bin_sync = 1'b0; bin_mag = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_index", out_index, 0);
    chk("rst_mag", out_mag, 0);
    chk("rst_last", out_last, 0);

    // Basic frame with exact first-word latency
    send(10, 10, 8);
    chk("lat_valid_c1", out_valid, 0);
    chk("lat_busy_c1", busy, 1);
    tick();
    chk("lat_valid_c2", out_valid, 1);
    drain(10, 10, 8, 1'b0, 1'b0);

    // Backpressure
    send(10, 10, 8);
    drain(10, 10, 8, 1'b1, 1'b0);

    // Mid-capture resync
    send(1, 1, 3);
    chk("resync_err_before", sync_err, 0);
    send(100, 1, 8);
    chk("resync_err", sync_err, 1);
    drain(100, 1, 8, 1'b0, 1'b0);

    // Drop counting while stalled
    out_ready = 1'b0;
    send(10, 10, 8);
    send(1, 1, 8); send(2, 1, 8); send(3, 1, 8);
    chk("drop_3", drop_count, 3);
    drain(10, 10, 8, 1'b0, 1'b0);
    send(200, 5, 8);
    drain(200, 5, 8, 1'b0, 1'b0);
    chk("drop_hold", drop_count, 3);

    // Saturation
    out_ready = 1'b0;
    send(10, 10, 8);
    for (int i = 0; i < 300; i++) begin
      bin_valid = 1'b1; bin_sync = 1'b1; bin_mag = '0;
      tick();
    end
    bin_valid = 1'b0; bin_sync = 1'b0;
    chk("drop_sat", drop_count, 255);
    drain(10, 10, 8, 1'b0, 1'b0);

    // Reset mid-drain after two transfers
    out_ready = 1'b1;
    send(10, 10, 8);
    tick();
    chk("mid_valid", out_valid, 1);
    tick(); tick();
    chk("mid_index", out_index, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_drop", drop_count, 0);
    chk("mrst_sync_err", sync_err, 0);

    // Sync on the exit cycle counts as dropped; next frame captured cleanly
    send(30, 1, 8);
    drain(30, 1, 8, 1'b0, 1'b1);
    chk("exit_drop", drop_count, 1);
    send(50, 2, 8);
    drain(50, 2, 8, 1'b0, 1'b0);

    // Half-frame instance: only bins 0..3 captured and drained
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bin_valid = (i < 8);
      bin_sync  = (i == 0);
      bin_mag   = (i < 4) ? MW'(hm[i]) : MW'(i - 2);
      if (i >= 5 && i <= 8) begin
        chk("half_valid", h_valid, 1);
        chk("half_index", h_index, i - 5);
        chk("half_mag", h_mag, hm[i-5]);
        chk("half_last", h_last, (i == 8));
      end else begin
        chk("half_idle_valid", h_valid, 0);
      end
      tick();
    end
    bin_valid = 1'b0; bin_sync = 1'b0;
    chk("half_busy", h_busy, 0);
    chk("half_drop", h_drop, 0);
`ifdef PEAK_TRACK_EN
    chk("peak_mag", h_pmag, 9);
    chk("peak_index", h_pidx, 2);
`endif
    for (int i = 0; i < 12; i++) tick();
    chk("full_done_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
